serial_link_receiver: RTL and testbench

- Receive side of the messenger serial link; sits directly downstream of the PISO-based encoder output.
- Frames the incoming one-bit-per-clock stream, deserialises characters LSB first, and checks parity and stop bits.
- Holds each good character in a one-entry buffer with a valid/ready handshake.
- Consumer is the decrypter/monitor path, which reads characters at its own pace.

---
 rtl/serial_link_receiver.sv | 124 ++++++++++++
 tb/tb_serial_link_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_receiver.sv
// Serial link receive path: frames a 1-bit-per-clock line, checks stop/parity, and buffers one character.
// Optional parity bit compiled in with `define SERIAL_LINK_RX_PARITY_EN.
module serial_link_receiver #(
    parameter int DATA_WIDTH      = 8,
    parameter int ODD_PARITY      = 0,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       serial_in,
    input  logic                       char_ready,
    output logic [DATA_WIDTH-1:0]      char_out,
    output logic                       char_valid,
    output logic                       parity_error,
    output logic                       framing_error,
    output logic                       overrun,
    output logic [ERR_COUNT_WIDTH-1:0] err_count,
    output logic                       busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] STOP   = 2'd3;
`ifdef SERIAL_LINK_RX_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic       ODD_BIT = (ODD_PARITY != 0);
`endif

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  parity_bad;

    logic stop_sample, stop_bad, par_bad_evt, commit, xfer, ovr_evt, err_evt;

`ifndef SERIAL_LINK_RX_PARITY_EN
    // No parity bit on the line, so ODD_PARITY has nothing to act on.
    assign parity_bad = 1'b0 && (ODD_PARITY != 0);
`endif

    always_comb begin
        stop_sample = (state == STOP) && enable;
        stop_bad    = stop_sample && !serial_in;
        par_bad_evt = stop_sample && serial_in && parity_bad;
        commit      = stop_sample && serial_in && !parity_bad;
        xfer        = char_valid && char_ready;
        ovr_evt     = commit && char_valid && !xfer;
        err_evt     = stop_bad || par_bad_evt || ovr_evt;
    end

    // Frame FSM; dropping enable abandons any partial frame silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef SERIAL_LINK_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    shift_reg[bit_idx] <= serial_in;
                    bit_idx            <= bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        bit_idx <= '0;
`ifdef SERIAL_LINK_RX_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= STOP;
`endif
                    end
                end
`ifdef SERIAL_LINK_RX_PARITY_EN
                PARITY: begin
                    parity_bad <= (^shift_reg) ^ serial_in ^ ODD_BIT;
                    state      <= STOP;
                end
`endif
                STOP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register, registered error pulses and saturating error count.
    always_ff @(posedge clock) begin
        if (reset) begin
            char_out      <= '0;
            char_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            err_count     <= '0;
        end else begin
            parity_error  <= par_bad_evt;
            framing_error <= stop_bad;
            overrun       <= ovr_evt;
            if (commit && (!char_valid || xfer)) begin
                char_out   <= shift_reg;
                char_valid <= 1'b1;
            end else if (xfer) begin
                char_valid <= 1'b0;
            end
            if (err_evt && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_link_receiver.sv
// Self-checking bench for serial_link_receiver: vector table, corner sequences, random frames vs frame-level model.
module tb_serial_link_receiver;

    localparam int DW = 8;
    localparam int OP = 0;
    localparam int CW = 8;
`ifdef SERIAL_LINK_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          serial_in = 1'b1;
    logic          char_ready = 1'b0;
    logic [DW-1:0] char_out;
    logic          char_valid, parity_error, framing_error, overrun, busy;
    logic [CW-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    serial_link_receiver #(.DATA_WIDTH(DW), .ODD_PARITY(OP), .ERR_COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .serial_in(serial_in),
        .char_ready(char_ready), .char_out(char_out), .char_valid(char_valid),
        .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun),
        .err_count(err_count), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        logic       stop_b;
        bit         read_first;
        bit         e_valid;
        logic [7:0] e_out;
        bit         e_perr;
        bit         e_ferr;
        bit         e_ovr;
        int         e_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic drive_bit(input logic b);
        serial_in = b;
        @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_b,
                              input bit rdy_stop, input bit pre_valid, input string tag);
        logic par;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (PAR_EN) begin
            par = (^d) ^ (OP != 0) ^ bad_par;
            drive_bit(par);
        end
        chk({tag, " pre-stop valid"}, char_valid, pre_valid);
        chk({tag, " pre-stop busy"}, busy, 1);
        char_ready = rdy_stop;
        drive_bit(stop_b);
        char_ready = 1'b0;
    endtask

    task automatic check_out(input string tag, input bit e_valid, input logic [7:0] e_out,
                             input bit e_perr, input bit e_ferr, input bit e_ovr, input int e_cnt);
        chk({tag, " char_valid"}, char_valid, e_valid);
        if (e_valid) chk({tag, " char_out"}, char_out, e_out);
        chk({tag, " parity_error"}, parity_error, e_perr);
        chk({tag, " framing_error"}, framing_error, e_ferr);
        chk({tag, " overrun"}, overrun, e_ovr);
        chk({tag, " err_count"}, err_count, e_cnt);
    endtask

    task automatic read_pulse(input string tag);
        serial_in  = 1'b1;
        char_ready = 1'b1;
        @(negedge clock);
        char_ready = 1'b0;
        chk({tag, " valid after read"}, char_valid, 0);
        chk({tag, " pulses idle"}, {parity_error, framing_error, overrun}, 0);
    endtask

    initial begin
        bit         prev_valid;
        int         cnt_tbl;
        logic [7:0] q[$];
        int         cnt;

        tbl[0] = '{8'h41, 0, 1'b1, 0, 1, 8'h41, 0, 0, 0, 0};
        tbl[1] = '{8'h41, 1, 1'b1, 1, !PAR_EN, 8'h41, PAR_EN, 0, 0, PAR_EN ? 1 : 0};
        tbl[2] = '{8'h2B, 0, 1'b0, 1, 0, 8'h00, 0, 1, 0, PAR_EN ? 2 : 1};
        tbl[3] = '{8'h41, 0, 1'b1, 0, 1, 8'h41, 0, 0, 0, PAR_EN ? 2 : 1};
        tbl[4] = '{8'h42, 0, 1'b1, 0, 1, 8'h41, 0, 0, 1, PAR_EN ? 3 : 2};
        tbl[5] = '{8'hC3, 0, 1'b1, 1, 1, 8'hC3, 0, 0, 0, PAR_EN ? 3 : 2};

        repeat (2) @(negedge clock);
        check_out("reset", 0, 8'h00, 0, 0, 0, 0);
        chk("reset char_out", char_out, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        drive_bit(1'b1);

        // Vector table
        prev_valid = 1'b0;
        foreach (tbl[r]) begin
            if (tbl[r].read_first) read_pulse($sformatf("row%0d", r));
            else begin
                drive_bit(1'b1);
                chk($sformatf("row%0d gap pulses", r), {parity_error, framing_error, overrun}, 0);
            end
            send_frame(tbl[r].data, tbl[r].bad_par, tbl[r].stop_b, 0,
                       !tbl[r].read_first && prev_valid, $sformatf("row%0d", r));
            check_out($sformatf("row%0d", r), tbl[r].e_valid, tbl[r].e_out,
                      tbl[r].e_perr, tbl[r].e_ferr, tbl[r].e_ovr, tbl[r].e_cnt);
            prev_valid = tbl[r].e_valid;
        end
        cnt_tbl = PAR_EN ? 3 : 2;

        // Commit coinciding with a transfer: buffer swaps without a gap or overrun
        read_pulse("simul pre");
        send_frame(8'h41, 0, 1'b1, 0, 0, "simul a");
        check_out("simul a", 1, 8'h41, 0, 0, 0, cnt_tbl);
        send_frame(8'h42, 0, 1'b1, 1, 1, "simul b");
        check_out("simul b", 1, 8'h42, 0, 0, 0, cnt_tbl);

        // Reset after four data bits
        drive_bit(1'b0);
        repeat (4) drive_bit(1'b1);
        serial_in = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check_out("midreset", 0, 8'h00, 0, 0, 0, 0);
        chk("midreset char_out", char_out, 0);
        chk("midreset busy", busy, 0);
        reset = 1'b0;
        drive_bit(1'b1);

        // Enable dropped mid-frame
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b0);
        enable = 1'b0;
        drive_bit(1'b0);
        chk("endrop busy", busy, 0);
        repeat (DW - 4 + (PAR_EN ? 1 : 0)) drive_bit(1'b0);
        drive_bit(1'b1);
        check_out("endrop", 0, 8'h00, 0, 0, 0, 0);
        enable = 1'b1;
        drive_bit(1'b1);
        send_frame(8'h5A, 0, 1'b1, 0, 0, "after en");
        check_out("after en", 1, 8'h5A, 0, 0, 0, 0);
        enable = 1'b0;
        read_pulse("read en low");
        enable = 1'b1;

        // Random frames against a frame-level model
        cnt = 0;
        q.delete();
        for (int f = 0; f < 150; f++) begin
            int         kind;
            int         gap;
            logic [7:0] d;
            bit         bp, sb, e_p, e_f, e_o, good;
            if ($urandom_range(0, 1) == 1) begin
                if (q.size() > 0) void'(q.pop_front());
                read_pulse("rnd read");
            end
            gap = $urandom_range(0, 2);
            repeat (gap) drive_bit(1'b1);
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            bp   = (kind == 7) || (kind == 8);
            sb   = (kind != 9);
            send_frame(d, bp, sb, 0, q.size() > 0, "rnd");
            e_f  = !sb;
            e_p  = sb && bp && PAR_EN;
            good = sb && !(bp && PAR_EN);
            e_o  = good && (q.size() > 0);
            if (good && q.size() == 0) q.push_back(d);
            if (e_f || e_p || e_o) cnt = (cnt < 255) ? cnt + 1 : 255;
            check_out($sformatf("rnd%0d", f), q.size() > 0, (q.size() > 0) ? q[0] : 8'h00,
                      e_p, e_f, e_o, cnt);
        end

        // Back-to-back framing errors until the counter saturates
        serial_in = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1);
        for (int i = 0; i < 260; i++) begin
            send_frame(8'(i), 0, 1'b0, 0, 0, "sat");
            if (i == 254) chk("sat reach", err_count, 255);
        end
        check_out("sat end", 0, 8'h00, 0, 1, 0, 255);
        drive_bit(1'b1);
        chk("sat pulse width", framing_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
